// File: rtl/config_frame_loader_if.sv
// Word-stream side of the frame loader: receiver words in, fabric frame writes out.
// The receiver (master) drives the word stream; the loader (slave) drives the frame bus.
interface config_frame_loader_if #(
  parameter int NUM_ROWS = 16,
  parameter int IDX_W    = 5
);
  logic                cfg_active;
  logic [31:0]         write_data;
  logic                write_strobe;
  logic [NUM_ROWS-1:0] row_select;
  logic [31:0]         frame_data;
  logic [IDX_W-1:0]    frame_index;
  logic                frame_strobe;
  logic                frame_done;
  logic                busy;
  logic                error;

  modport master (
    output cfg_active, write_data, write_strobe,
    input  row_select, frame_data, frame_index, frame_strobe, frame_done, busy, error
  );

  modport slave (
    input  cfg_active, write_data, write_strobe,
    output row_select, frame_data, frame_index, frame_strobe, frame_done, busy, error
  );
endinterface

// File: rtl/config_frame_loader.sv
// Turns configuration receiver words into per-row fabric frame writes.
// A tagged header word selects a row, then FRAME_WORDS data words are forwarded.
module config_frame_loader #(
  parameter int          NUM_ROWS    = 16,
  parameter int          FRAME_WORDS = 20,
  parameter int          IDX_W       = 5,
  parameter logic [15:0] HEADER_TAG  = 16'hFA5E
) (
  input  logic                  clk,
  input  logic                  reset,
  config_frame_loader_if.slave  bus
);

  typedef enum logic {IDLE, DATA} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  function automatic logic header_ok(input logic [31:0] w);
    return (w[31:16] == HEADER_TAG) && (int'(w[7:0]) < NUM_ROWS);
  endfunction

  function automatic logic [NUM_ROWS-1:0] one_hot_row(input logic [7:0] r);
    return NUM_ROWS'(1) << r;
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                cfg_active_p0;
  logic [NUM_ROWS-1:0] row_select_p1, row_select_d;
  logic [31:0]         frame_data_p1, frame_data_d;
  logic [IDX_W-1:0]    frame_index_p1, frame_index_d;
  logic                vld_p1, vld_d;
  logic                done_p1, done_d;
  logic                error_p1, error_d;

  logic accept, cfg_rise, cfg_fall;

  // Input stage: session edge detection and strobe qualification
  assign accept   = bus.write_strobe & bus.cfg_active;
  assign cfg_rise = ~cfg_active_p0 &  bus.cfg_active;
  assign cfg_fall =  cfg_active_p0 & ~bus.cfg_active;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_select_d  = row_select_p1;
    frame_data_d  = frame_data_p1;
    frame_index_d = frame_index_p1;
    vld_d         = 1'b0;
    done_d        = 1'b0;
    error_d       = error_p1;
    // Rising session edge clears; any error raised below in the same cycle wins
    if (cfg_rise) error_d = 1'b0;
    case (state_q)
      IDLE: begin
        row_select_d = '0;
        if (accept) begin
          if (header_ok(bus.write_data)) begin
            row_select_d = one_hot_row(bus.write_data[7:0]);
            cnt_d        = '0;
            state_d      = DATA;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      DATA: begin
        // A falling session edge implies cfg_active=0, so a strobe here is already ignored
        if (cfg_fall) begin
          state_d      = IDLE;
          row_select_d = '0;
          error_d      = 1'b1;
        end else if (accept) begin
          frame_data_d  = bus.write_data;
          frame_index_d = cnt_q;
          vld_d         = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: registered frame bus, strobe one cycle after the accepted word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cfg_active_p0  <= 1'b0;
      row_select_p1  <= '0;
      frame_data_p1  <= '0;
      frame_index_p1 <= '0;
      vld_p1         <= 1'b0;
      done_p1        <= 1'b0;
      error_p1       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cfg_active_p0  <= bus.cfg_active;
      row_select_p1  <= row_select_d;
      frame_data_p1  <= frame_data_d;
      frame_index_p1 <= frame_index_d;
      vld_p1         <= vld_d;
      done_p1        <= done_d;
      error_p1       <= error_d;
    end
  end

  assign bus.row_select   = row_select_p1;
  assign bus.frame_data   = frame_data_p1;
  assign bus.frame_index  = frame_index_p1;
  assign bus.frame_strobe = vld_p1;
  assign bus.frame_done   = done_p1;
  assign bus.busy         = (state_q == DATA);
  assign bus.error        = error_p1;

endmodule
